// File: rtl/mem_bist_64x16.sv
// March C- BIST controller for the 64x16 dual-port SRAM wrapper: port-0 march, port-1 read sweep,
// pass/fail with first-failure address and element.
module mem_bist_64x16 #(
    parameter int unsigned    DEPTH   = 64,
    parameter int unsigned    AW      = 6,
    parameter int unsigned    DW      = 16,
    parameter logic [DW-1:0]  PATTERN = 16'h0000
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          pass_o,
    output logic [AW-1:0] fail_addr_o,
    output logic [2:0]    fail_elem_o,
    output logic [7:0]    err_cnt_o,
    output logic [AW-1:0] a0_o,
    output logic [DW-1:0] d0_o,
    output logic [DW-1:0] wem0_o,
    output logic          ce0_o,
    output logic          we0_o,
    input  logic [DW-1:0] q0_i,
    output logic [AW-1:0] a1_o,
    output logic [DW-1:0] d1_o,
    output logic [DW-1:0] wem1_o,
    output logic          ce1_o,
    output logic          we1_o,
    input  logic [DW-1:0] q1_i
);

    localparam logic [3:0] StIdle  = 4'd0;
    localparam logic [3:0] StM0    = 4'd1;
    localparam logic [3:0] StM1    = 4'd2;
    localparam logic [3:0] StM2    = 4'd3;
    localparam logic [3:0] StM3    = 4'd4;
    localparam logic [3:0] StM4    = 4'd5;
    localparam logic [3:0] StM5    = 4'd6;
    localparam logic [3:0] StM6    = 4'd7;
    localparam logic [3:0] StDrain = 4'd8;
    localparam logic [3:0] StFin   = 4'd9;

    localparam logic [AW-1:0] AddrLast = AW'(DEPTH - 1);

    logic [3:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;
    logic [DW-1:0] e_q, e_d;
    logic          v_q, v_d;
    logic [AW-1:0] af_q, af_d;
    logic [2:0]    ef_q, ef_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [2:0]    fail_elem_q, fail_elem_d;
    logic          pass_q, pass_d;
    logic          done_q, done_d;

    logic          ce0, we0, ce1, rd;
    logic [DW-1:0] d0, rd_exp;
    logic          miscmp;

    // Access decode depends only on registered state and phase (phase 0 = read, 1 = write).
    always_comb begin
        ce0    = 1'b0;
        we0    = 1'b0;
        ce1    = 1'b0;
        rd     = 1'b0;
        d0     = PATTERN;
        rd_exp = PATTERN;
        case (state_q)
            StM0: begin
                ce0 = 1'b1;
                we0 = 1'b1;
            end
            StM1, StM3: begin
                ce0    = 1'b1;
                we0    = phase_q;
                rd     = ~phase_q;
                d0     = ~PATTERN;
                rd_exp = PATTERN;
            end
            StM2, StM4: begin
                ce0    = 1'b1;
                we0    = phase_q;
                rd     = ~phase_q;
                d0     = PATTERN;
                rd_exp = ~PATTERN;
            end
            StM5: begin
                ce0 = 1'b1;
                rd  = 1'b1;
            end
            StM6: begin
                ce1 = 1'b1;
                rd  = 1'b1;
            end
            default: ;
        endcase
    end

    assign miscmp = v_q && (((ef_q == 3'd6) ? q1_i : q0_i) != e_q);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        phase_d     = phase_q;
        err_cnt_d   = err_cnt_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        pass_d      = pass_q;
        done_d      = done_q;
        v_d         = rd;
        e_d         = rd_exp;
        af_d        = addr_q;
        ef_d        = state_q[2:0] - 3'd1;

        if (miscmp) begin
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
            if (err_cnt_q == 8'd0) begin
                fail_addr_d = af_q;
                fail_elem_d = ef_q;
            end
        end

        case (state_q)
            StIdle, StFin: begin
                if (start_i) begin
                    state_d     = StM0;
                    addr_d      = '0;
                    phase_d     = 1'b0;
                    err_cnt_d   = 8'd0;
                    fail_addr_d = '0;
                    fail_elem_d = 3'd0;
                    pass_d      = 1'b0;
                    done_d      = 1'b0;
                end
            end
            StM0, StM5, StM6: begin
                addr_d = addr_q + 1'b1;
                if (addr_q == AddrLast) begin
                    state_d = state_q + 4'd1;
                    addr_d  = '0;
                end
            end
            StM1, StM2: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    addr_d = addr_q + 1'b1;
                    if (addr_q == AddrLast) begin
                        state_d = state_q + 4'd1;
                        addr_d  = (state_q == StM2) ? AddrLast : '0;
                    end
                end
            end
            StM3, StM4: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    addr_d = addr_q - 1'b1;
                    if (addr_q == '0) begin
                        state_d = state_q + 4'd1;
                        addr_d  = (state_q == StM3) ? AddrLast : '0;
                    end
                end
            end
            StDrain: begin
                // The last port-1 compare lands on this edge, so judge on the next count.
                state_d = StFin;
                done_d  = 1'b1;
                pass_d  = (err_cnt_d == 8'd0);
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            e_q         <= '0;
            v_q         <= 1'b0;
            af_q        <= '0;
            ef_q        <= 3'd0;
            err_cnt_q   <= 8'd0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            pass_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            phase_q     <= phase_d;
            e_q         <= e_d;
            v_q         <= v_d;
            af_q        <= af_d;
            ef_q        <= ef_d;
            err_cnt_q   <= err_cnt_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
            pass_q      <= pass_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = (state_q != StIdle) && (state_q != StFin);
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign err_cnt_o   = err_cnt_q;
    assign a0_o        = addr_q;
    assign d0_o        = d0;
    assign wem0_o      = '1;
    assign ce0_o       = ce0;
    assign we0_o       = we0;
    assign a1_o        = addr_q;
    assign d1_o        = '0;
    assign wem1_o      = '1;
    assign ce1_o       = ce1;
    assign we1_o       = 1'b0;

endmodule

// File: tb/tb_mem_bist_64x16.sv
// Bench for mem_bist_64x16: behavioural dual-port SRAM with injectable read-path faults,
// per-cycle access-trace scoreboard and end-of-run result scoreboard.
module tb_mem_bist_64x16;

    typedef struct packed {
        logic       ce0;
        logic       we0;
        logic [5:0] a0;
        logic [15:0] d0;
        logic       ce1;
        logic [5:0] a1;
    } acc_t;

    typedef struct packed {
        logic       pass;
        logic [7:0] err;
        logic [5:0] faddr;
        logic [2:0] felem;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start_a, start_b, sel_b;
    int   fault_mode;
    int   total = 0;
    int   bad = 0;

    acc_t exp_q[$];
    res_t res_q[$];

    logic        a_busy, a_done, a_pass, a_ce0, a_we0, a_ce1, a_we1;
    logic [5:0]  a_faddr, a_a0, a_a1;
    logic [2:0]  a_felem;
    logic [7:0]  a_err;
    logic [15:0] a_d0, a_wem0, a_d1, a_wem1;
    logic        b_busy, b_done, b_pass, b_ce0, b_we0, b_ce1, b_we1;
    logic [5:0]  b_faddr, b_a0, b_a1;
    logic [2:0]  b_felem;
    logic [7:0]  b_err;
    logic [15:0] b_d0, b_wem0, b_d1, b_wem1;
    logic [15:0] q0, q1;

    mem_bist_64x16 u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_a),
        .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass),
        .fail_addr_o(a_faddr), .fail_elem_o(a_felem), .err_cnt_o(a_err),
        .a0_o(a_a0), .d0_o(a_d0), .wem0_o(a_wem0), .ce0_o(a_ce0), .we0_o(a_we0), .q0_i(q0),
        .a1_o(a_a1), .d1_o(a_d1), .wem1_o(a_wem1), .ce1_o(a_ce1), .we1_o(a_we1), .q1_i(q1)
    );

    mem_bist_64x16 #(.PATTERN(16'hA5A5)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start_b),
        .busy_o(b_busy), .done_o(b_done), .pass_o(b_pass),
        .fail_addr_o(b_faddr), .fail_elem_o(b_felem), .err_cnt_o(b_err),
        .a0_o(b_a0), .d0_o(b_d0), .wem0_o(b_wem0), .ce0_o(b_ce0), .we0_o(b_we0), .q0_i(q0),
        .a1_o(b_a1), .d1_o(b_d1), .wem1_o(b_wem1), .ce1_o(b_ce1), .we1_o(b_we1), .q1_i(q1)
    );

    // Observed/driving signals of whichever DUT currently owns the memory.
    wire        m_ce0  = sel_b ? b_ce0  : a_ce0;
    wire        m_we0  = sel_b ? b_we0  : a_we0;
    wire [5:0]  m_a0   = sel_b ? b_a0   : a_a0;
    wire [15:0] m_d0   = sel_b ? b_d0   : a_d0;
    wire [15:0] m_wem0 = sel_b ? b_wem0 : a_wem0;
    wire        m_ce1  = sel_b ? b_ce1  : a_ce1;
    wire        m_we1  = sel_b ? b_we1  : a_we1;
    wire [5:0]  m_a1   = sel_b ? b_a1   : a_a1;
    wire [15:0] m_d1   = sel_b ? b_d1   : a_d1;
    wire [15:0] m_wem1 = sel_b ? b_wem1 : a_wem1;
    wire        m_busy = sel_b ? b_busy : a_busy;
    wire        m_done = sel_b ? b_done : a_done;
    wire        m_pass = sel_b ? b_pass : a_pass;
    wire [7:0]  m_err  = sel_b ? b_err  : a_err;
    wire [5:0]  m_faddr = sel_b ? b_faddr : a_faddr;
    wire [2:0]  m_felem = sel_b ? b_felem : a_felem;

    logic [15:0] mem [64];

    // Mode 1: port-0 read path forces bit 3 high at address 17. Mode 2: port-1 flips bit 0 at 63.
    always @(posedge clk) begin
        if (m_ce0 && m_we0) mem[m_a0] <= (mem[m_a0] & ~m_wem0) | (m_d0 & m_wem0);
        if (m_ce0 && !m_we0)
            q0 <= mem[m_a0] | ((fault_mode == 1 && m_a0 == 6'd17) ? 16'h0008 : 16'h0000);
        if (m_ce1 && !m_we1)
            q1 <= mem[m_a1] ^ ((fault_mode == 2 && m_a1 == 6'd63) ? 16'h0001 : 16'h0000);
    end

    function automatic void pa(input logic ce0, input logic we0, input int a,
                               input logic [15:0] d, input logic ce1);
        acc_t t;
        t.ce0 = ce0;
        t.we0 = we0;
        t.a0  = 6'(a);
        t.d0  = d;
        t.ce1 = ce1;
        t.a1  = 6'(a);
        exp_q.push_back(t);
    endfunction

    // Expected March C- access sequence, one entry per cycle from cycle 1 through DRAIN.
    function automatic void push_trace(input logic [15:0] b);
        for (int a = 0; a < 64; a++) pa(1, 1, a, b, 0);
        for (int a = 0; a < 64; a++) begin pa(1, 0, a, b, 0); pa(1, 1, a, ~b, 0); end
        for (int a = 0; a < 64; a++) begin pa(1, 0, a, b, 0); pa(1, 1, a, b, 0); end
        for (int a = 63; a >= 0; a--) begin pa(1, 0, a, b, 0); pa(1, 1, a, ~b, 0); end
        for (int a = 63; a >= 0; a--) begin pa(1, 0, a, b, 0); pa(1, 1, a, b, 0); end
        for (int a = 0; a < 64; a++) pa(1, 0, a, b, 0);
        for (int a = 0; a < 64; a++) pa(0, 0, a, b, 1);
        pa(0, 0, 0, b, 0);
    endfunction

    task automatic set_start(input logic use_b, input logic v);
        if (use_b) start_b = v;
        else start_a = v;
    endtask

    task automatic do_run(input logic use_b, input logic [15:0] b, input int poke,
                          input int abort, input res_t exp_r);
        acc_t t;
        res_t r;
        logic ok;
        sel_b = use_b;
        push_trace(b);
        res_q.push_back(exp_r);
        @(negedge clk);
        set_start(use_b, 1'b1);
        @(posedge clk);
        #1;
        set_start(use_b, 1'b0);
        for (int k = 1; k <= 705; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            t = exp_q.pop_front();
            ok = (m_ce0 === t.ce0) && (m_we0 === t.we0) && (m_ce1 === t.ce1) &&
                 (!t.ce0 || m_a0 === t.a0) && (!t.we0 || m_d0 === t.d0) &&
                 (!t.ce1 || m_a1 === t.a1) && (m_busy === 1'b1) && (m_done === 1'b0) &&
                 (m_we1 === 1'b0) && (m_d1 === 16'h0) && (m_wem0 === 16'hFFFF) &&
                 (m_wem1 === 16'hFFFF);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL trace cycle %0d: got ce0=%b we0=%b a0=%0d d0=%h ce1=%b a1=%0d busy=%b done=%b, want ce0=%b we0=%b a0=%0d d0=%h ce1=%b a1=%0d busy=1 done=0",
                         k, m_ce0, m_we0, m_a0, m_d0, m_ce1, m_a1, m_busy, m_done,
                         t.ce0, t.we0, t.a0, t.d0, t.ce1, t.a1);
            end
            if (k == 1) begin
                total++;
                if ({m_pass, m_err, m_faddr, m_felem} !== 18'h0) begin
                    bad++;
                    $display("FAIL start_clear: got pass=%b err=%0d faddr=%0d felem=%0d, want all 0",
                             m_pass, m_err, m_faddr, m_felem);
                end
            end
            if (poke > 0 && k == poke) set_start(use_b, 1'b1);
            if (poke > 0 && k == poke + 1) set_start(use_b, 1'b0);
            if (abort > 0 && k == abort) begin
                rst_n = 1'b0;
                #2;
                total++;
                if ({m_ce0, m_we0, m_ce1, m_busy, m_done, m_pass, m_err, m_faddr, m_felem}
                    !== 23'h0) begin
                    bad++;
                    $display("FAIL async_reset: got ce0=%b ce1=%b busy=%b done=%b pass=%b err=%0d faddr=%0d felem=%0d, want all 0",
                             m_ce0, m_ce1, m_busy, m_done, m_pass, m_err, m_faddr, m_felem);
                end
                exp_q.delete();
                res_q.delete();
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        @(posedge clk);
        #1;
        r = res_q.pop_front();
        total++;
        if (m_done !== 1'b1 || m_busy !== 1'b0 || m_pass !== r.pass || m_err !== r.err ||
            m_faddr !== r.faddr || m_felem !== r.felem) begin
            bad++;
            $display("FAIL result: got done=%b busy=%b pass=%b err=%0d faddr=%0d felem=%0d, want done=1 busy=0 pass=%b err=%0d faddr=%0d felem=%0d",
                     m_done, m_busy, m_pass, m_err, m_faddr, m_felem,
                     r.pass, r.err, r.faddr, r.felem);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        sel_b = 1'b0;
        fault_mode = 0;
        #12;
        total++;
        if ({a_ce0, a_ce1, a_busy, a_done, a_pass, a_err, a_faddr, a_felem, b_ce0, b_busy}
            !== 24'h0) begin
            bad++;
            $display("FAIL reset_state: got ce0=%b ce1=%b busy=%b done=%b pass=%b err=%0d faddr=%0d felem=%0d, want all 0",
                     a_ce0, a_ce1, a_busy, a_done, a_pass, a_err, a_faddr, a_felem);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (a_busy !== 1'b0 || a_ce0 !== 1'b0 || a_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: got busy=%b ce0=%b done=%b, want 0 0 0", a_busy, a_ce0, a_done);
        end
    endtask

    task automatic test_fault_free;
        fault_mode = 0;
        do_run(1'b0, 16'h0000, 0, 0, '{pass: 1'b1, err: 8'd0, faddr: 6'd0, felem: 3'd0});
    endtask

    task automatic test_stuck_at;
        fault_mode = 1;
        do_run(1'b0, 16'h0000, 0, 0, '{pass: 1'b0, err: 8'd3, faddr: 6'd17, felem: 3'd1});
    endtask

    task automatic test_port1_flip;
        fault_mode = 2;
        do_run(1'b0, 16'h0000, 0, 0, '{pass: 1'b0, err: 8'd1, faddr: 6'd63, felem: 3'd6});
    endtask

    task automatic test_back_to_back;
        fault_mode = 0;
        do_run(1'b0, 16'h0000, 100, 0, '{pass: 1'b1, err: 8'd0, faddr: 6'd0, felem: 3'd0});
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (a_done !== 1'b1 || a_pass !== 1'b1 || a_busy !== 1'b0) begin
            bad++;
            $display("FAIL fin_hold: got done=%b pass=%b busy=%b, want 1 1 0", a_done, a_pass, a_busy);
        end
        do_run(1'b0, 16'h0000, 0, 0, '{pass: 1'b1, err: 8'd0, faddr: 6'd0, felem: 3'd0});
    endtask

    task automatic test_reset_mid_run;
        fault_mode = 0;
        do_run(1'b0, 16'h0000, 0, 300, '{pass: 1'b1, err: 8'd0, faddr: 6'd0, felem: 3'd0});
        do_run(1'b0, 16'h0000, 0, 0, '{pass: 1'b1, err: 8'd0, faddr: 6'd0, felem: 3'd0});
    endtask

    task automatic test_pattern_a5;
        fault_mode = 0;
        do_run(1'b1, 16'hA5A5, 0, 0, '{pass: 1'b1, err: 8'd0, faddr: 6'd0, felem: 3'd0});
    endtask

    initial begin
        test_reset();
        test_fault_free();
        test_stuck_at();
        test_port1_flip();
        test_back_to_back();
        test_reset_mid_run();
        test_pattern_a5();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_bist_64x16.md
# mem_bist_64x16

Built-in self-test controller for the 64x16 dual-port SRAM wrapper. It acts as the initiator side of the wrapper's generic memory interface (active-high CE/WE, full-width WEM, synchronous read). On START it runs March C- on port 0, then a read-back sweep on port 1, and reports pass/fail with first-failure diagnostics. It sits between the wrapper and the chip test-control logic, muxed in front of functional traffic.

## Interface
- DEPTH, 64: number of words. Must equal 2**AW.
- AW, 6: address width.
- DW, 16: data width.
- PATTERN, 16'h0000: background written as "0". "1" is ~PATTERN.
- CLK  in  1  clock; all state updates on the rising edge.
- RST_N  in  1  reset. One clock; reset is asynchronous and active-low.
- START  in  1  level-sampled run request, honoured only in IDLE or FIN.
- BUSY  out  1  high from the first access cycle through DRAIN. Reset 0.
- DONE  out  1  high in FIN and held until the next START or reset. Reset 0.
- PASS  out  1  valid when DONE=1: 1 means no miscompare. Reset 0.
- FAIL_ADDR  out  AW  address of the first miscompare. Reset 0.
- FAIL_ELEM  out  3  march element (0-6) of the first miscompare. Reset 0.
- ERR_CNT  out  8  miscompare count, saturating at 255. Reset 0.
- A0, D0, WEM0  out  AW/DW/DW  port-0 address, write data and write mask. WEM0 is all ones.
- CE0, WE0  out  1  port-0 enable and write strobe. Reset 0.
- Q0  in  DW  port-0 read data.
- A1, D1, WEM1  out  AW/DW/DW  port-1 signals. D1=0 and WEM1 is all ones.
- CE1, WE1  out  1  port-1 enable and write strobe. WE1 is tied 0. CE1 resets to 0.
- Q1  in  DW  port-1 read data.

## Operation
- States: IDLE, M0, M1, M2, M3, M4, M5, M6, DRAIN, FIN.
- Memory outputs are decoded from registered state, address and phase only. They never depend on START or Q.
- March elements (B = PATTERN, B' = ~PATTERN):
  - M0 ⇑w(B), 1 cycle per address.
  - M1 ⇑(r B, w B'), 2 cycles per address.
  - M2 ⇑(r B', w B), 2 cycles per address.
  - M3 ⇓(r B, w B'), 2 cycles per address.
  - M4 ⇓(r B', w B), 2 cycles per address.
  - M5 ⇑r(B) on port 0, 1 cycle per address.
  - M6 ⇑r(B) on port 1, 1 cycle per address.
- ⇑ means addresses 0..DEPTH-1; ⇓ means DEPTH-1..0.
- Read cycle: CE=1, WE=0. Write cycle: CE=1, WE=1, WEM all ones.
- Port 1 is idle (CE1=0) in M0-M5. Port 0 is idle (CE0=0) in M6, DRAIN, IDLE and FIN.
- Compare pipeline:
  - Each read loads expect register E, expect-valid V, address AF and element EF.
  - On the next edge, if V=1 and Q≠E (Q0 for elements 0-5, Q1 for element 6), a miscompare is recorded.
  - In M1-M4 the compare happens during the write cycle of the same address.
- Miscompare effects:
  - ERR_CNT increments, saturating at 255.
  - The first miscompare of a run latches FAIL_ADDR←AF and FAIL_ELEM←EF. Later miscompares do not update them.
  - PASS is computed in FIN as ERR_CNT==0.
- Element transitions occur after the last address of the element. M6 goes to DRAIN, which completes the final compare, then to FIN.
- START handling:
  - In IDLE or FIN, START=1 clears ERR_CNT, FAIL_ADDR, FAIL_ELEM, PASS and DONE, then enters M0 at address 0.
  - START is ignored in all other states. A run cannot be aborted except by reset.
- Reset mid-run: all registers and outputs return to reset values immediately. CE0 and CE1 drop without waiting for CLK. The next run starts from M0.

## Timing
- START is sampled at edge E0. Cycle 1 (after E0) is the M0 write to address 0, with BUSY=1.
- Access cycles total 11*DEPTH (704 at DEPTH=64):
  - M0: cycles 1-64.
  - M1-M4: cycles 65-576.
  - M5: cycles 577-640.
  - M6: cycles 641-704.
- DRAIN is cycle 705. At edge E0+705: DONE=1, BUSY=0, PASS valid.
- Read latency is 1. Q is valid in the cycle after the read cycle and is compared at the end of that cycle.
- The address counter wraps only at element boundaries, never mid-element.

## Test plan
- Fault-free model, PATTERN=0, START held 1 cycle:
  - DONE rises exactly 705 edges after START.
  - PASS=1, ERR_CNT=0.
  - CE0/WE0 trace matches the March C- sequence.
- Bit 3 stuck-at-1 at address 17:
  - First failure is the M1 read of addr 17: FAIL_ADDR=17, FAIL_ELEM=1.
  - ERR_CNT=3 (M1, M3 and M5 reads).
  - PASS=0.
- Port-1 read path flips bit 0 at address 63 only:
  - FAIL_ELEM=6, FAIL_ADDR=63, ERR_CNT=1, PASS=0.
- PATTERN=16'hA5A5, fault-free:
  - M1 read expects A5A5 and writes 5A5A.
  - PASS=1 after 705 cycles.
- RST_N pulsed low at cycle 300:
  - CE0=0 asynchronously; all outputs at reset values.
  - START then gives a full 705-cycle run with PASS=1.
- START re-asserted at cycle 100 and in FIN:
  - Mid-run START is ignored; timing is unchanged.
  - START in FIN clears DONE and the flags and reruns.
